uart_rx_command_parser: RTL and testbench
=========================================

UART_RX_COMMAND_PARSER -- requirements
Module: uart_rx_command_parser

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of received bytes and data fields.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 4, meaning the register address width taken from the low bits of the address byte.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum clk cycles allowed between bytes of one frame.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  block clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 data_valid  in  1  one-cycle pulse: received byte available.
REQ-008 parallel_data  in  DATA_WIDTH  received byte, valid with data_valid.
REQ-009 parity_error  in  1  parity mismatch, qualified by data_valid.
REQ-010 frame_error  in  1  start/stop bit error, qualified by data_valid.
REQ-011 cmd_ready  in  1  downstream accepts the pending command.
REQ-012 cmd_valid  out  1  decoded command pending.
REQ-013 cmd_type  out  2  0 = write, 1 = read, 2 = ALU with operands, 3 = ALU without operands.
REQ-014 cmd_address  out  ADDRESS_WIDTH  register address.
REQ-015 cmd_data  out  DATA_WIDTH  write data, or ALU operand A.
REQ-016 cmd_operand_b  out  DATA_WIDTH  ALU operand B.
REQ-017 cmd_function  out  4  ALU function code, the low 4 bits of the function byte.
REQ-018 rx_error  out  1  one-cycle pulse: a byte was discarded because parity_error or frame_error was set.
REQ-019 bad_command  out  1  one-cycle pulse: an unknown opcode was received in IDLE.
REQ-020 overrun_error  out  1  one-cycle pulse: a byte was dropped while a command was pending.
REQ-021 timeout_error  out  1  one-cycle pulse: a frame was abandoned by the inter-byte timeout.

Function
REQ-022 The FSM SHALL have the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC and HOLD.
REQ-023 In IDLE, a clean byte SHALL select the next state: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> ALU_A; 0xDD -> ALU_FUNC with cmd_type = 3; any other value -> stay in IDLE and pulse bad_command.
REQ-024 A write frame SHALL be WR_ADDR (capture the address) -> WR_DATA (capture cmd_data) -> HOLD with cmd_type = 0.
REQ-025 A read frame SHALL be RD_ADDR (capture the address) -> HOLD with cmd_type = 1.
REQ-026 An ALU frame with operands SHALL be ALU_A (capture cmd_data) -> ALU_B (capture cmd_operand_b) -> ALU_FUNC (capture the function code) -> HOLD with cmd_type = 2.
REQ-027 A clean byte is data_valid=1 with parity_error=0 and frame_error=0; the FSM SHALL advance only on clean bytes.
REQ-028 A byte with data_valid=1 and parity_error or frame_error set SHALL be discarded in any state except HOLD, and SHALL pulse rx_error the next cycle.
REQ-029 Such an error byte received in a parsing state SHALL also return the FSM to IDLE.
REQ-030 cmd_valid SHALL rise in the cycle after the data_valid of the final byte of a frame (latency 1).
REQ-031 cmd_valid SHALL stay high until cmd_ready is sampled high, and SHALL be low in the following cycle.
REQ-032 All cmd_* outputs SHALL be stable while cmd_valid is high.
REQ-033 While in HOLD, any byte arriving in a cycle where cmd_ready=0 SHALL be dropped and SHALL pulse overrun_error, whether clean or not.
REQ-034 A byte arriving in the same cycle that cmd_ready=1 is sampled in HOLD SHALL be processed as if the FSM were in IDLE.
REQ-035 In parsing states other than IDLE and HOLD, an inter-byte counter SHALL clear on each data_valid and increment otherwise.
REQ-036 When that counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE and pulse timeout_error.
REQ-037 If the counter reaches its limit in the same cycle as a data_valid, the byte SHALL win and no timeout SHALL occur.
REQ-038 An address byte SHALL supply bits [ADDRESS_WIDTH-1:0] to cmd_address; its upper bits SHALL be ignored.
REQ-039 All error pulses SHALL be registered and SHALL be exactly one cycle wide.

Reset
REQ-040 When reset=1 at a rising clk edge, the FSM SHALL go to IDLE and the inter-byte counter SHALL clear.
REQ-041 When reset=1 at a rising clk edge, every output SHALL become 0, including cmd_valid, all cmd_* fields and all error pulses.
REQ-042 A reset in the middle of a frame or in HOLD SHALL discard the partial or pending command without any error pulse.

Verification
REQ-043 Bytes AA,05,3C with cmd_ready=1 -> one cmd_valid pulse, one cycle after the third byte, with type=0, address=5, data=0x3C.
REQ-044 Bytes CC,12,34,07 with cmd_ready=0 for 10 cycles -> cmd_valid held with type=2, data=0x12, operand_b=0x34, function=7; it drops the cycle after cmd_ready=1.
REQ-045 Bytes BB then 03 with parity_error=1 -> rx_error pulse, FSM back in IDLE; a following BB,03 -> type=1, address=3.
REQ-046 A byte 0x55 in IDLE -> bad_command pulse and no cmd_valid; with TIMEOUT_CYCLES=16, byte AA followed by 16 idle cycles -> timeout_error pulse and FSM in IDLE.
REQ-047 Command pending with cmd_ready=0 and byte DD arriving -> overrun_error pulse; byte DD arriving in the cmd_ready=1 cycle instead -> it starts a new frame.
REQ-048 reset asserted after bytes CC,12 -> all outputs 0; next DD,04 -> type=3, function=4.

Source files
------------

// File: rtl/uart_rx_command_parser_if.sv
// rtl/uart_rx_command_parser_if.sv - received-byte and decoded-command signal bundle
//
// Purpose : groups the byte-receive inputs and the command/error outputs of the
//           UART command parser so they travel as one port.
// Signals : data_valid, parallel_data, parity_error, frame_error  - received byte
//           cmd_ready                                              - downstream accept
//           cmd_valid, cmd_type, cmd_address, cmd_data,
//           cmd_operand_b, cmd_function                            - decoded command
//           rx_error, bad_command, overrun_error, timeout_error    - one-cycle pulses
// Modports: master - the parser (consumes bytes, produces commands)
//           slave  - the environment (produces bytes, consumes commands)

interface uart_rx_command_parser_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
);
   logic                     data_valid;
   logic [DATA_WIDTH-1:0]    parallel_data;
   logic                     parity_error;
   logic                     frame_error;
   logic                     cmd_ready;
   logic                     cmd_valid;
   logic [1:0]               cmd_type;
   logic [ADDRESS_WIDTH-1:0] cmd_address;
   logic [DATA_WIDTH-1:0]    cmd_data;
   logic [DATA_WIDTH-1:0]    cmd_operand_b;
   logic [3:0]               cmd_function;
   logic                     rx_error;
   logic                     bad_command;
   logic                     overrun_error;
   logic                     timeout_error;

   modport master (
      input  data_valid, parallel_data, parity_error, frame_error, cmd_ready,
      output cmd_valid, cmd_type, cmd_address, cmd_data, cmd_operand_b, cmd_function,
      output rx_error, bad_command, overrun_error, timeout_error
   );

   modport slave (
      output data_valid, parallel_data, parity_error, frame_error, cmd_ready,
      input  cmd_valid, cmd_type, cmd_address, cmd_data, cmd_operand_b, cmd_function,
      input  rx_error, bad_command, overrun_error, timeout_error
   );
endinterface

// File: rtl/uart_rx_command_parser.sv
// rtl/uart_rx_command_parser.sv - UART byte-stream command frame parser
//
// Purpose : assembles write / read / ALU command frames from received UART bytes
//           and presents each decoded command with a valid/ready handshake.
// Ports   : clk   - block clock, rising edge
//           reset - synchronous, active-high
//           bus   - uart_rx_command_parser_if.master (byte input, command output,
//                   rx_error / bad_command / overrun_error / timeout_error pulses)

module uart_rx_command_parser #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   uart_rx_command_parser_if.master  bus
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [DATA_WIDTH-1:0] OP_WRITE   = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] OP_READ    = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, HOLD
   } state_t;

   state_t                   state_q,         state_d;
   logic [CNT_W-1:0]         count_q,         count_d;
   logic                     cmd_valid_q,     cmd_valid_d;
   logic [1:0]               cmd_type_q,      cmd_type_d;
   logic [ADDRESS_WIDTH-1:0] cmd_address_q,   cmd_address_d;
   logic [DATA_WIDTH-1:0]    cmd_data_q,      cmd_data_d;
   logic [DATA_WIDTH-1:0]    cmd_operand_b_q, cmd_operand_b_d;
   logic [3:0]               cmd_function_q,  cmd_function_d;
   logic                     rx_error_q,      rx_error_d;
   logic                     bad_command_q,   bad_command_d;
   logic                     overrun_error_q, overrun_error_d;
   logic                     timeout_error_q, timeout_error_d;

   logic clean_byte;
   logic bad_byte;
   logic idle_like;

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      cmd_valid_d     = cmd_valid_q;
      cmd_type_d      = cmd_type_q;
      cmd_address_d   = cmd_address_q;
      cmd_data_d      = cmd_data_q;
      cmd_operand_b_d = cmd_operand_b_q;
      cmd_function_d  = cmd_function_q;
      rx_error_d      = 1'b0;
      bad_command_d   = 1'b0;
      overrun_error_d = 1'b0;
      timeout_error_d = 1'b0;

      clean_byte = bus.data_valid & ~bus.parity_error & ~bus.frame_error;
      bad_byte   = bus.data_valid & (bus.parity_error | bus.frame_error);
      // The handshake cycle of a pending command doubles as an IDLE cycle, so a
      // byte landing exactly then is decoded instead of being lost.
      idle_like  = (state_q == IDLE) || ((state_q == HOLD) && bus.cmd_ready);

      if (state_q == HOLD) begin
         if (bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
            state_d     = IDLE;
         end else if (bus.data_valid) begin
            overrun_error_d = 1'b1;
         end
      end

      if (idle_like) begin
         count_d = '0;
         if (bad_byte) begin
            rx_error_d = 1'b1;
         end else if (clean_byte) begin
            // Fields are cleared at the opcode so a short frame never carries
            // leftovers from the previous command.
            cmd_address_d   = '0;
            cmd_data_d      = '0;
            cmd_operand_b_d = '0;
            cmd_function_d  = '0;
            case (bus.parallel_data)
               OP_WRITE: begin
                  state_d    = WR_ADDR;
                  cmd_type_d = 2'd0;
               end
               OP_READ: begin
                  state_d    = RD_ADDR;
                  cmd_type_d = 2'd1;
               end
               OP_ALU: begin
                  state_d    = ALU_A;
                  cmd_type_d = 2'd2;
               end
               OP_ALU_NOP: begin
                  state_d    = ALU_FUNC;
                  cmd_type_d = 2'd3;
               end
               default: begin
                  bad_command_d = 1'b1;
               end
            endcase
         end
      end else if (state_q != HOLD) begin
         if (bad_byte) begin
            rx_error_d = 1'b1;
            state_d    = IDLE;
            count_d    = '0;
         end else if (clean_byte) begin
            count_d = '0;
            case (state_q)
               WR_ADDR: begin
                  cmd_address_d = bus.parallel_data[ADDRESS_WIDTH-1:0];
                  state_d       = WR_DATA;
               end
               WR_DATA: begin
                  cmd_data_d  = bus.parallel_data;
                  cmd_valid_d = 1'b1;
                  state_d     = HOLD;
               end
               RD_ADDR: begin
                  cmd_address_d = bus.parallel_data[ADDRESS_WIDTH-1:0];
                  cmd_valid_d   = 1'b1;
                  state_d       = HOLD;
               end
               ALU_A: begin
                  cmd_data_d = bus.parallel_data;
                  state_d    = ALU_B;
               end
               ALU_B: begin
                  cmd_operand_b_d = bus.parallel_data;
                  state_d         = ALU_FUNC;
               end
               ALU_FUNC: begin
                  cmd_function_d = bus.parallel_data[3:0];
                  cmd_valid_d    = 1'b1;
                  state_d        = HOLD;
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end else if (count_q == CNT_LAST) begin
            // Only reached without a byte this cycle: an arriving byte wins.
            timeout_error_d = 1'b1;
            state_d         = IDLE;
            count_d         = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         count_q         <= '0;
         cmd_valid_q     <= 1'b0;
         cmd_type_q      <= '0;
         cmd_address_q   <= '0;
         cmd_data_q      <= '0;
         cmd_operand_b_q <= '0;
         cmd_function_q  <= '0;
         rx_error_q      <= 1'b0;
         bad_command_q   <= 1'b0;
         overrun_error_q <= 1'b0;
         timeout_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         cmd_valid_q     <= cmd_valid_d;
         cmd_type_q      <= cmd_type_d;
         cmd_address_q   <= cmd_address_d;
         cmd_data_q      <= cmd_data_d;
         cmd_operand_b_q <= cmd_operand_b_d;
         cmd_function_q  <= cmd_function_d;
         rx_error_q      <= rx_error_d;
         bad_command_q   <= bad_command_d;
         overrun_error_q <= overrun_error_d;
         timeout_error_q <= timeout_error_d;
      end
   end

   assign bus.cmd_valid     = cmd_valid_q;
   assign bus.cmd_type      = cmd_type_q;
   assign bus.cmd_address   = cmd_address_q;
   assign bus.cmd_data      = cmd_data_q;
   assign bus.cmd_operand_b = cmd_operand_b_q;
   assign bus.cmd_function  = cmd_function_q;
   assign bus.rx_error      = rx_error_q;
   assign bus.bad_command   = bad_command_q;
   assign bus.overrun_error = overrun_error_q;
   assign bus.timeout_error = timeout_error_q;

endmodule

// File: tb/tb_uart_rx_command_parser.sv
// tb/tb_uart_rx_command_parser.sv - self-checking bench for uart_rx_command_parser

module tb_uart_rx_command_parser;

   localparam int TO = 16;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   uart_rx_command_parser_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

   uart_rx_command_parser #(
      .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a frame is a list of bytes; its opcode fixes its length.
   logic [7:0] frame[$];
   int         gap;
   bit         m_pend;
   logic [1:0] m_type;
   logic [3:0] m_addr;
   logic [7:0] m_data;
   logic [7:0] m_opb;
   logic [3:0] m_func;
   logic [3:0] m_err;   // {rx, bad_command, overrun, timeout}

   function automatic int frame_len(input logic [7:0] op);
      case (op)
         8'hAA:   return 3;
         8'hBB:   return 2;
         8'hCC:   return 4;
         8'hDD:   return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      frame.delete();
      gap    = 0;
      m_pend = 0;
      m_err  = '0;
   endtask

   task automatic model_finish_frame();
      logic [7:0] f1, f2, f3;
      f1 = frame[1];
      f2 = (frame.size() > 2) ? frame[2] : 8'h00;
      f3 = (frame.size() > 3) ? frame[3] : 8'h00;
      m_pend = 1;
      case (frame[0])
         8'hAA: begin m_type = 2'd0; m_addr = f1[3:0]; m_data = f2; end
         8'hBB: begin m_type = 2'd1; m_addr = f1[3:0]; end
         8'hCC: begin m_type = 2'd2; m_data = f1; m_opb = f2; m_func = f3[3:0]; end
         default: begin m_type = 2'd3; m_func = f1[3:0]; end
      endcase
      frame.delete();
   endtask

   task automatic model_step(input bit dv, input logic [7:0] b, input bit pe, input bit fe,
                             input bit rdy);
      m_err = '0;
      if (m_pend && rdy) m_pend = 0;
      if (m_pend) begin
         if (dv) m_err[1] = 1'b1;
      end else if (dv) begin
         gap = 0;
         if (pe || fe) begin
            m_err[3] = 1'b1;
            frame.delete();
         end else if (frame.size() == 0) begin
            if (frame_len(b) != 0) frame.push_back(b);
            else m_err[2] = 1'b1;
         end else begin
            frame.push_back(b);
            if (frame.size() == frame_len(frame[0])) model_finish_frame();
         end
      end else if (frame.size() != 0) begin
         gap++;
         if (gap == TO) begin
            m_err[0] = 1'b1;
            frame.delete();
            gap = 0;
         end
      end
   endtask

   // Fields only matter for the expected command type while a command is expected.
   function automatic logic [30:0] pack(input logic v, input logic [1:0] t, input logic [3:0] a,
                                        input logic [7:0] d, input logic [7:0] ob,
                                        input logic [3:0] f, input logic [3:0] e);
      logic [30:0] r;
      r = {v, 30'd0};
      r[3:0] = e;
      if (m_pend) begin
         r[29:28] = t;
         if (m_type == 2'd0 || m_type == 2'd1) r[27:24] = a;
         if (m_type == 2'd0 || m_type == 2'd2) r[23:16] = d;
         if (m_type == 2'd2) r[15:8] = ob;
         if (m_type == 2'd2 || m_type == 2'd3) r[7:4] = f;
      end
      return r;
   endfunction

   function automatic logic [30:0] obs_vec();
      return pack(bus.cmd_valid, bus.cmd_type, bus.cmd_address, bus.cmd_data, bus.cmd_operand_b,
                  bus.cmd_function,
                  {bus.rx_error, bus.bad_command, bus.overrun_error, bus.timeout_error});
   endfunction

   function automatic logic [30:0] exp_vec();
      return pack(m_pend, m_type, m_addr, m_data, m_opb, m_func, m_err);
   endfunction

   function automatic logic [30:0] raw_vec();
      return {bus.cmd_valid, bus.cmd_type, bus.cmd_address, bus.cmd_data, bus.cmd_operand_b,
              bus.cmd_function, bus.rx_error, bus.bad_command, bus.overrun_error,
              bus.timeout_error};
   endfunction

   task automatic tick(input bit dv, input logic [7:0] b, input bit pe, input bit fe,
                       input bit rdy);
      bus.data_valid    = dv;
      bus.parallel_data = b;
      bus.parity_error  = pe;
      bus.frame_error   = fe;
      bus.cmd_ready     = rdy;
      @(posedge clk);
      model_step(dv, b, pe, fe, rdy);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      bus.data_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(1, 8'hAA, 0, 0, 0);
      tick(0, 8'h00, 0, 0, 0);
      total++;
      if (raw_vec() !== 31'd0) begin
         bad++;
         $display("FAIL reset_outputs got %h want %h", raw_vec(), 31'd0);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_write();
      logic [7:0] seq[6] = '{8'hAA, 8'h05, 8'h3C, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
         tick(i < 3, seq[i], 0, 0, 1);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL write step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_alu_hold();
      logic [7:0] seq[4] = '{8'hCC, 8'h12, 8'h34, 8'h07};
      for (int i = 0; i < 17; i++) begin
         tick(i < 4, (i < 4) ? seq[i] : 8'h00, 0, 0, i == 14);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL alu_hold step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_rx_error();
      logic [7:0] seq[7] = '{8'hBB, 8'h03, 8'h11, 8'hBB, 8'h03, 8'h00, 8'h00};
      for (int i = 0; i < 7; i++) begin
         tick(i < 5, seq[i], i == 1, i == 2, 1);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL rx_error step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_bad_timeout();
      // 0x55, then AA with a full timeout gap, then AA,05,3C with the data byte
      // landing exactly on the last allowed cycle.
      for (int i = 0; i < 72; i++) begin
         bit         dv;
         logic [7:0] b;
         dv = 0;
         b  = 8'h00;
         if (i == 0)  begin dv = 1; b = 8'h55; end
         if (i == 3)  begin dv = 1; b = 8'hAA; end
         if (i == 25) begin dv = 1; b = 8'hAA; end
         if (i == 41) begin dv = 1; b = 8'h05; end
         if (i == 57) begin dv = 1; b = 8'h3C; end
         tick(dv, b, 0, 0, 1);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL bad_timeout step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_overrun();
      logic [7:0] seq[8] = '{8'hAA, 8'h01, 8'h02, 8'hDD, 8'h00, 8'hDD, 8'h09, 8'h00};
      bit         dvs[8] = '{1, 1, 1, 1, 0, 1, 1, 0};
      bit         rdy[8] = '{0, 0, 0, 0, 0, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         tick(dvs[i], seq[i], 0, 0, rdy[i]);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL overrun step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      tick(1, 8'hCC, 0, 0, 0);
      tick(1, 8'h12, 0, 0, 0);
      pulse_reset();
      total++;
      if (raw_vec() !== 31'd0) begin
         bad++;
         $display("FAIL reset_mid_frame got %h want %h", raw_vec(), 31'd0);
      end
      for (int i = 0; i < 4; i++) begin
         tick(i < 2, (i == 0) ? 8'hDD : 8'h04, 0, 0, i == 3);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_then_dd step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq[11] = '{8'hAA, 8'h01, 8'h02, 8'hBB, 8'hF7, 8'hDD, 8'h0F, 8'hCC, 8'h81,
                              8'h82, 8'hF3};
      for (int i = 0; i < 13; i++) begin
         tick(i < 11, (i < 11) ? seq[i] : 8'h00, 0, 0, 1);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL back_to_back step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ops[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      int         quiet;
      quiet = 0;
      for (int i = 0; i < 1500; i++) begin
         bit         dv;
         logic [7:0] b;
         if (quiet == 0 && $urandom_range(0, 39) == 0) quiet = $urandom_range(14, 18);
         dv = (quiet == 0) && ($urandom_range(0, 1) == 1);
         if (quiet != 0) quiet--;
         b  = ($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, 3)] : 8'($urandom);
         tick(dv, b, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random cycle %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.data_valid    = 1'b0;
      bus.parallel_data = 8'h00;
      bus.parity_error  = 1'b0;
      bus.frame_error   = 1'b0;
      bus.cmd_ready     = 1'b0;
      model_reset();
      test_reset();
      test_write();
      test_alu_hold();
      test_rx_error();
      test_bad_timeout();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
